uart_rx_datapath: RTL and testbench

- Receive datapath paired with the UART receive control FSM, clocked at twice the baud rate.
- Samples `rx` on each `enable` pulse from the control FSM and deserialises the start bit plus 8 data bits, LSB first.
- Uses its own cycle count to sample the parity and stop bits, where the control FSM gives no `enable`.
- Publishes the byte with parity/framing status and a ready/read handshake toward the host side.

---
 rtl/uart_rx_datapath_if.sv | 14 +
 rtl/uart_rx_datapath.sv | 106 ++++++++++
 tb/tb_uart_rx_datapath.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/uart_rx_datapath_if.sv
// uart_rx_datapath_if: serial input, host handshake and frame status of the receive datapath
interface uart_rx_datapath_if;
  logic       rx;
  logic       enable;
  logic       rd;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       data_ready;
  logic       parity_err;
  logic       frame_err;
  logic       overrun;
  modport master (output rx, enable, rd, input rx_data, rx_valid, data_ready, parity_err, frame_err, overrun);
  modport slave  (input rx, enable, rd, output rx_data, rx_valid, data_ready, parity_err, frame_err, overrun);
endinterface

// File: rtl/uart_rx_datapath.sv
// uart_rx_datapath: deserialises enable-strobed UART frames at 2x baud, self-times parity/stop, host ready/read handshake
module uart_rx_datapath #(
  parameter bit PARITY_ODD = 1'b0,
  parameter int GAP_MAX    = 3
) (
  input logic              clk_2br,
  input logic              reset,
  uart_rx_datapath_if.slave bus
);
  localparam logic [1:0] IDLE = 2'd0, DATA = 2'd1, TAIL = 2'd2;
  localparam int GW = $clog2(GAP_MAX + 2);
  localparam logic [GW-1:0] GAP_LIM = GW'(GAP_MAX);
  logic [1:0]    state_q, state_d;
  logic [3:0]    bit_q, bit_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [2:0]    tail_q, tail_d;
  logic [7:0]    shift_q, shift_d;
  logic          start_q, start_d, par_q, par_d, stop_q, stop_d, commit_q, commit_d;
  logic [7:0]    data_q;
  logic          valid_q, ready_q, perr_q, ferr_q, ovr_q;
  always_comb begin
    state_d  = state_q;
    bit_d    = bit_q;
    gap_d    = gap_q;
    tail_d   = tail_q;
    shift_d  = shift_q;
    start_d  = start_q;
    par_d    = par_q;
    stop_d   = stop_q;
    commit_d = 1'b0;
    case (state_q)
      IDLE: if (bus.enable) begin
        start_d = bus.rx;
        bit_d   = 4'd0;
        gap_d   = '0;
        state_d = DATA;
      end
      DATA: if (bus.enable) begin
        shift_d = {bus.rx, shift_q[7:1]};
        bit_d   = bit_q + 4'd1;
        gap_d   = '0;
        state_d = (bit_q == 4'd7) ? TAIL : DATA;
        tail_d  = 3'd0;
      end else begin
        gap_d   = gap_q + 1'b1;
        state_d = (gap_q >= GAP_LIM) ? IDLE : DATA;
      end
      TAIL: begin
        // parity sits two edges and stop four edges after the last data sample
        tail_d   = tail_q + 3'd1;
        par_d    = (tail_q == 3'd1) ? bus.rx : par_q;
        stop_d   = (tail_q == 3'd3) ? bus.rx : stop_q;
        commit_d = (tail_q == 3'd3);
        state_d  = (tail_q == 3'd3) ? IDLE : TAIL;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_2br or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      bit_q    <= '0;
      gap_q    <= '0;
      tail_q   <= '0;
      shift_q  <= '0;
      start_q  <= 1'b0;
      par_q    <= 1'b0;
      stop_q   <= 1'b0;
      commit_q <= 1'b0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      ready_q  <= 1'b0;
      perr_q   <= 1'b0;
      ferr_q   <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      bit_q    <= bit_d;
      gap_q    <= gap_d;
      tail_q   <= tail_d;
      shift_q  <= shift_d;
      start_q  <= start_d;
      par_q    <= par_d;
      stop_q   <= stop_d;
      commit_q <= commit_d;
      valid_q  <= commit_q;
      // a commit beats a simultaneous host read
      if (commit_q) begin
        data_q  <= shift_q;
        perr_q  <= ((^shift_q) ^ par_q) != PARITY_ODD;
        ferr_q  <= start_q | ~stop_q;
        ovr_q   <= ovr_q | ready_q;
        ready_q <= 1'b1;
      end else if (bus.rd) begin
        ready_q <= 1'b0;
        ovr_q   <= 1'b0;
      end
    end
  end
  assign bus.rx_data    = data_q;
  assign bus.rx_valid   = valid_q;
  assign bus.data_ready = ready_q;
  assign bus.parity_err = perr_q;
  assign bus.frame_err  = ferr_q;
  assign bus.overrun    = ovr_q;
endmodule

// File: tb/tb_uart_rx_datapath.sv
// tb_uart_rx_datapath: random and directed frames against a frame-level model, scoreboard monitor on rx_valid
module tb_uart_rx_datapath;
  logic clk_2br = 1'b0;
  logic reset = 1'b1;
  always #5 clk_2br = ~clk_2br;
  uart_rx_datapath_if b0 ();
  uart_rx_datapath_if b1 ();
  assign b1.rx     = b0.rx;
  assign b1.enable = b0.enable;
  assign b1.rd     = b0.rd;
  uart_rx_datapath #(.PARITY_ODD(1'b0), .GAP_MAX(3)) dut0 (.clk_2br(clk_2br), .reset(reset), .bus(b0.slave));
  uart_rx_datapath #(.PARITY_ODD(1'b1), .GAP_MAX(3)) dut1 (.clk_2br(clk_2br), .reset(reset), .bus(b1.slave));
  typedef struct {
    logic [7:0] d;
    logic pe, po, fe, ov;
    int cyc;
  } exp_t;
  exp_t q[$];
  exp_t me;
  int checks = 0, errors = 0, cyc = 0;
  logic m_ready = 1'b0, m_ovr = 1'b0;
  logic [7:0] m_data = 8'h00;
  always @(posedge clk_2br) cyc <= cyc + 1;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask
  always @(negedge clk_2br) if (!reset && b0.rx_valid) begin
    if (q.size() == 0) chk("unexpected_valid", 32'd1, 32'd0);
    else begin
      me = q.pop_front();
      chk("valid_cycle", cyc, me.cyc);
      chk("rx_data", b0.rx_data, me.d);
      chk("parity_err_even", b0.parity_err, me.pe);
      chk("frame_err", b0.frame_err, me.fe);
      chk("overrun", b0.overrun, me.ov);
      chk("data_ready", b0.data_ready, 1);
      chk("odd_valid", b1.rx_valid, 1);
      chk("parity_err_odd", b1.parity_err, me.po);
    end
  end
  // frame slots: start, d0..d7 carry enable; parity and stop rely on the datapath's own timing
  task automatic send(input logic [7:0] d, input logic p, input logic s, input logic st,
                      input int nslots, input bit rd_commit);
    logic [10:0] fr;
    int ecyc, ones;
    exp_t e;
    fr = {st, p, d, s};
    ecyc = 0;
    for (int k = 0; k < nslots; k++) begin
      @(negedge clk_2br);
      b0.rx = fr[k];
      b0.enable = (k < 9);
      if (k == 8) ecyc = cyc + 6;
      @(negedge clk_2br);
      b0.enable = 1'b0;
      if (k == 10) b0.rd = rd_commit;
    end
    if (nslots == 11) begin
      ones = $countones(d) + int'(p);
      e.d = d;
      e.pe = (ones % 2) != 0;
      e.po = (ones % 2) != 1;
      e.fe = s | ~st;
      e.ov = m_ovr | m_ready;
      e.cyc = ecyc;
      q.push_back(e);
      m_ovr = e.ov;
      m_ready = 1'b1;
      m_data = d;
      @(negedge clk_2br);
      b0.rd = 1'b0;
      b0.rx = 1'b1;
      repeat (2) @(negedge clk_2br);
    end
  endtask
  task automatic do_rd();
    @(negedge clk_2br);
    b0.rd = 1'b1;
    @(negedge clk_2br);
    b0.rd = 1'b0;
    m_ready = 1'b0;
    m_ovr = 1'b0;
    chk("rd_data_ready", b0.data_ready, m_ready);
    chk("rd_overrun", b0.overrun, m_ovr);
  endtask
  task automatic chk_cleared(input string tag);
    chk({tag, "_rx_data"}, b0.rx_data, 0);
    chk({tag, "_valid"}, b0.rx_valid, 0);
    chk({tag, "_ready"}, b0.data_ready, 0);
    chk({tag, "_perr"}, b0.parity_err, 0);
    chk({tag, "_ferr"}, b0.frame_err, 0);
    chk({tag, "_ovr"}, b0.overrun, 0);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end
  initial begin
    logic [7:0] d;
    logic p, s, st;
    b0.rx = 1'b1;
    b0.enable = 1'b0;
    b0.rd = 1'b0;
    repeat (3) @(negedge clk_2br);
    chk_cleared("reset");
    reset = 1'b0;
    send(8'hA5, 1'b0, 1'b0, 1'b1, 11, 1'b0);
    do_rd();
    send(8'h01, 1'b0, 1'b0, 1'b1, 11, 1'b0);
    do_rd();
    send(8'h3C, 1'b0, 1'b0, 1'b0, 11, 1'b0);
    do_rd();
    send(8'h42, 1'b0, 1'b1, 1'b1, 11, 1'b0);
    do_rd();
    send(8'h11, 1'b0, 1'b0, 1'b1, 11, 1'b0);
    send(8'h22, 1'b0, 1'b0, 1'b1, 11, 1'b0);
    chk("overrun_sticky", b0.overrun, 1);
    do_rd();
    send(8'hC3, 1'b0, 1'b0, 1'b1, 5, 1'b0);
    repeat (8) @(negedge clk_2br);
    chk("abort_held_data", b0.rx_data, m_data);
    chk("abort_ready", b0.data_ready, m_ready);
    send(8'h7E, 1'b0, 1'b0, 1'b1, 11, 1'b0);
    do_rd();
    send(8'h55, 1'b0, 1'b0, 1'b1, 11, 1'b0);
    send(8'h66, 1'b0, 1'b0, 1'b1, 11, 1'b1);
    chk("rd_vs_commit_ready", b0.data_ready, 1);
    do_rd();
    send(8'h99, 1'b1, 1'b0, 1'b0, 11, 1'b0);
    send(8'h5A, 1'b0, 1'b0, 1'b1, 10, 1'b0);
    #2 reset = 1'b1;
    #1 chk_cleared("midtail_reset");
    @(negedge clk_2br);
    reset = 1'b0;
    b0.rx = 1'b1;
    m_ready = 1'b0;
    m_ovr = 1'b0;
    m_data = 8'h00;
    send(8'hFF, 1'b0, 1'b0, 1'b1, 11, 1'b0);
    do_rd();
    for (int n = 0; n < 40; n++) begin
      d = 8'($urandom);
      p = (^d) ^ ($urandom_range(0, 3) == 0);
      s = ($urandom_range(0, 7) == 0);
      st = ($urandom_range(0, 7) != 0);
      send(d, p, s, st, 11, $urandom_range(0, 4) == 0);
      if ($urandom_range(0, 1) == 1) do_rd();
    end
    repeat (10) @(negedge clk_2br);
    chk("scoreboard_drained", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
